// File: rtl/bcd_digit_entry.sv
// bcd_digit_entry
//   Calculator-style digit entry register fed by a decimal-to-BCD encoder,
//   plus a time-multiplexed, active-low seven-segment display of the number.
//
//   Each key press enters one BCD digit. The new digit goes into the
//   least-significant position and the older digits move one position up.
//   A press is rejected, with a one-cycle err pulse, when the code is not a
//   decimal digit or when the register is already full.
//
//   Optional build macro:
//     BCD_LEADING_ZERO_BLANK_EN - blank leading zero digits. Digit 0 is
//                                 always shown.
//
//   Parameters:
//     NUM_DIGITS  number of BCD digits stored and displayed (>= 2)
//     SCAN_DIV    clock cycles each display digit stays lit (>= 2)
//
//   Ports:
//     clk        system clock; all state changes on the rising edge
//     rst_n      asynchronous active-low reset
//     key_valid  level, high while any encoder input line is active
//     bcd_in     BCD code from the encoder, sampled on an accepted press
//     clear      synchronous clear of the entry register
//     value      stored digits; [3:0] is the most recently entered digit
//     count      number of digits entered (0..NUM_DIGITS)
//     full       high when count == NUM_DIGITS
//     err        one-cycle pulse on a rejected press
//     seg_n      segments {g,f,e,d,c,b,a}, active-low
//     an_n       digit enables, one-hot active-low; bit 0 = rightmost digit
module bcd_digit_entry #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              key_valid,
    input  logic [3:0]                        bcd_in,
    input  logic                              clear,
    output logic [4*NUM_DIGITS-1:0]           value,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
    output logic                              full,
    output logic                              err,
    output logic [6:0]                        seg_n,
    output logic [NUM_DIGITS-1:0]             an_n
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);

    localparam logic [CW-1:0] FULL_CNT = CW'(NUM_DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // ------------------------------------------------------------------
    // Key press FSM
    // ------------------------------------------------------------------
    // Reset lands in HELD so a key that is already down when reset is
    // released is not taken as a press until it has been let go.
    typedef enum logic {
        IDLE,
        HELD
    } key_state_t;

    key_state_t state;
    key_state_t state_next;
    logic       accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HELD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (key_valid)  state_next = HELD;
            HELD:    if (!key_valid) state_next = IDLE;
            default: state_next = HELD;
        endcase
    end

    // The IDLE->HELD cycle is the only cycle in which a press is accepted.
    always_comb begin
        accept = 1'b0;
        if (state == IDLE && key_valid) begin
            accept = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Entry register
    // ------------------------------------------------------------------
    logic bad_code;

    assign bad_code = (bcd_in > 4'd9);
    assign full     = (count == FULL_CNT);

    // clear takes priority over a press in the same cycle. The press is
    // dropped, but the FSM still moves to HELD, so the held key does not
    // enter a digit after the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (clear) begin
            value <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            err <= accept && (bad_code || full);
            if (accept && !bad_code && !full) begin
                value <= {value[4*NUM_DIGITS-5:0], bcd_in};
                count <= count + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [PW-1:0] prescale;
    logic [IW-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            idx      <= '0;
        end else if (prescale == PS_LAST) begin
            prescale <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [3:0]            digit;
    logic                  blank;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    assign digit = value[4*idx +: 4];

`ifdef BCD_LEADING_ZERO_BLANK_EN
    // zero_from[i] is high when digit i and every digit above it are zero.
    logic [NUM_DIGITS-1:0] zero_from;

    always_comb begin
        zero_from = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            zero_from[i] = ~|(value >> (4 * i));
        end
    end

    assign blank = (idx != '0) && zero_from[idx];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_next = blank ? SEG_BLANK : seg_decode(digit);
        an_next  = ~(NUM_DIGITS'(1) << idx);
    end

    // Both outputs come from the same idx in the same register stage, so
    // the segment pattern never leads or lags its digit enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= 7'b1000000;
            an_n  <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
        end else begin
            seg_n <= seg_next;
            an_n  <= an_next;
        end
    end

endmodule

// File: doc/bcd_digit_entry.md
Name: bcd_digit_entry

Overview:
- Downstream consumer of the decimal-to-BCD encoder. Takes the 4-bit BCD code and a key-active level from the encoder stage.
- Captures one digit per key press into a NUM_DIGITS-digit entry register, shifting in from the least-significant side (calculator style).
- Drives a time-multiplexed, active-low seven-segment display of the stored number.

Parameters:
- NUM_DIGITS, 4: number of BCD digits stored and displayed (≥2).
- SCAN_DIV, 1000: clock cycles each display digit stays lit (≥2).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  level; high while any encoder input line is active.
- bcd_in  in  4  BCD code from encoder; sampled only on an accepted press.
- clear  in  1  synchronous clear of the entry register.
- value  out  4*NUM_DIGITS  stored digits; [3:0] is the most recently entered digit.
- count  out  $clog2(NUM_DIGITS+1)  number of digits entered (0..NUM_DIGITS).
- full  out  1  high when count == NUM_DIGITS.
- err  out  1  one-cycle pulse on a rejected press.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an_n  out  NUM_DIGITS  digit enables, one-hot active-low; bit 0 = rightmost digit.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low. Assertion mid-operation clears all state immediately.
- Reset values:
  - value=0, count=0, full=0, err=0.
  - prescaler=0, scan index=0.
  - an_n = all ones except bit0=0; seg_n = code for digit0 of value=0 (7'b1000000).
  - Key FSM resets to HELD.
- Key FSM states: IDLE, HELD.
  - IDLE -> HELD when key_valid=1. That cycle is the press-accept cycle.
  - HELD -> IDLE when key_valid=0.
  - Reset into HELD means a key already held at reset release is ignored until released.
- Accept action, evaluated in the accept cycle; results visible the next clock edge (1-cycle latency):
  - bcd_in > 9: err=1 for one cycle; value and count unchanged.
  - full=1: err=1 for one cycle; no shift, no overwrite.
  - Otherwise: value <= {value[4*NUM_DIGITS-5:0], bcd_in}; count <= count+1.
- clear:
  - value=0, count=0, err=0 next edge.
  - clear has priority over a same-cycle accept; the press is discarded.
  - The FSM still moves to HELD, so a held key does not re-enter after clear.
- Display scan:
  - Prescaler counts 0..SCAN_DIV-1. On terminal count it wraps to 0 and the scan index increments, wrapping NUM_DIGITS-1 -> 0.
  - an_n and seg_n are both registered from the same index, so they stay aligned.
  - seg_n decodes value[4*idx+3:4*idx]:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
    - 10-15=1111111 (blank; unreachable in normal operation).
  - Scanning is independent of entry; value changes show on the next scan of that digit.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined: any digit position idx ≥ 1 is blanked (seg_n=1111111) when it and every higher digit are zero. Digit 0 is always shown, so value 0 displays a single "0". an_n scanning is unchanged.
- Undefined: all NUM_DIGITS digits are always displayed, including leading zeros.

Test Plan:
1. Reset, then press-release 1,2,3,4 (key_valid high 3 cycles each, 2-cycle gaps) -> value=16'h1234, count=4, full=1, err never asserted.
2. With value=16'h1234, press 5 -> err high exactly one cycle; value stays 16'h1234, count stays 4.
3. From reset-then-idle, hold key_valid high 50 cycles with bcd_in=7 -> exactly one entry: value=16'h0007, count=1.
4. Press with bcd_in=4'hA -> err one-cycle pulse; value and count unchanged. Next valid press of 3 is accepted normally.
5. Assert clear in the same cycle as a press of 9, with key held 10 more cycles -> value=0, count=0 and no entry. Release, then press 9 -> value=16'h0009.
6. SCAN_DIV=4, value=16'h1234 -> an_n cycles 1110, 1101, 1011, 0111, changing every 4 cycles; seg_n = 0011001, 0110000, 0100100, 1111001 respectively.
   - With BCD_LEADING_ZERO_BLANK_EN and value=16'h0012: positions 2 and 3 show 1111111, position 0 shows 0100100.
